cpu_out_uart: RTL and testbench

- Downstream consumer of the cpu output port.
- Accepts byte writes from the cpu, buffers them in a small FIFO, and serialises them as 8N1 UART frames on a single tx line.
- Gives the bench and board a visible byte stream from the running program.
- Drives backpressure to the cpu so it stalls instead of losing bytes.

---
 rtl/cpu_out_uart_pkg.sv | 19 +
 rtl/uart_tx_fifo.sv | 59 +++++
 rtl/cpu_out_uart.sv | 134 +++++++++++++
 tb/tb_cpu_out_uart.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_out_uart_pkg.sv
// Shared types and helpers for the cpu output-port UART.
package cpu_out_uart_pkg;

  localparam int BYTE_W = 8;

  // PARITY stays in the encoding so both builds share one state type.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the cpu output port and the UART shifter; full is registered.
module uart_tx_fifo
  import cpu_out_uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BYTE_W-1:0]        wdata,
  output logic [BYTE_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [CW-1:0]     count_nxt;
  logic              wr, rd;

  // A pop in the same cycle never frees room for a push into a full FIFO.
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  always_comb begin
    count_nxt = count;
    case ({wr, rd})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/cpu_out_uart.sv
// cpu output port -> byte FIFO -> 8N1 UART transmitter with backpressure.
// Define CPU_OUT_UART_PARITY_EN to insert an even-parity bit before the stop bit.
module cpu_out_uart
  import cpu_out_uart_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          out_we,
  input  logic [7:0]                    out_data,
  output logic                          out_full,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  uart_state_t       state;
  logic [15:0]       div;
  logic [2:0]        bitidx;
  logic [BYTE_W-1:0] shift;
  logic [BYTE_W-1:0] head;
  logic              empty;
  logic              pop;
  logic              div_done;
`ifdef CPU_OUT_UART_PARITY_EN
  logic              par;
`endif

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_we),
    .pop   (pop),
    .wdata (out_data),
    .rdata (head),
    .count (fifo_count),
    .full  (out_full),
    .empty (empty)
  );

  assign pop      = (state == IDLE) && !empty;
  assign div_done = (div == DIV_LAST);
  assign busy     = (state != IDLE) || (fifo_count != '0);

  // tx is always the registered next-bit value, so the line never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      div      <= '0;
      bitidx   <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
`ifdef CPU_OUT_UART_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      if (out_we && out_full) overflow <= 1'b1;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shift <= head;
            div   <= '0;
            tx    <= 1'b0;
            state <= START;
`ifdef CPU_OUT_UART_PARITY_EN
            par   <= even_parity(head);
`endif
          end
        end
        START: begin
          if (div_done) begin
            div    <= '0;
            bitidx <= '0;
            tx     <= shift[0];
            state  <= DATA;
          end else begin
            div <= div + 16'd1;
          end
        end
        DATA: begin
          if (div_done) begin
            div   <= '0;
            shift <= shift >> 1;
            if (bitidx == 3'd7) begin
`ifdef CPU_OUT_UART_PARITY_EN
              tx    <= par;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bitidx <= bitidx + 3'd1;
              tx     <= shift[1];
            end
          end else begin
            div <= div + 16'd1;
          end
        end
`ifdef CPU_OUT_UART_PARITY_EN
        PARITY: begin
          if (div_done) begin
            div   <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            div <= div + 16'd1;
          end
        end
`endif
        STOP: begin
          if (div_done) begin
            div   <= '0;
            state <= IDLE;
          end else begin
            div <= div + 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_out_uart.sv
// Directed bench for cpu_out_uart: exact frame timing, overflow, backpressure, reset abort, wrap.
module tb_cpu_out_uart;

  localparam int CD    = 4;
  localparam int DEPTH = 8;
`ifdef CPU_OUT_UART_PARITY_EN
  localparam int FRAME = 11 * CD;
`else
  localparam int FRAME = 10 * CD;
`endif

  logic       clk, rst, out_we;
  logic [7:0] out_data;
  logic       out_full, tx, busy, overflow;
  logic [3:0] fifo_count;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int stop_err = 0;
  int maxc;
  logic [7:0] rxq[$];
  logic       parq[$];

  cpu_out_uart #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .out_we     (out_we),
    .out_data   (out_data),
    .out_full   (out_full),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
    end
    chk(tag, (n < 3000), 1);
    tick();
    tick();
  endtask

  // Expected tx level sampled just after edge k, for a byte written at edge 1 from idle.
  function automatic logic exp_tx(input int k, input logic [7:0] d);
    if (k < 2) return 1'b1;
    if (k < 2 + CD) return 1'b0;
    if (k < 2 + 9 * CD) return d[(k - 2 - CD) / CD];
`ifdef CPU_OUT_UART_PARITY_EN
    if (k < 2 + 10 * CD) return ^d;
`endif
    return 1'b1;
  endfunction

  // Line receiver: mid-bit sampling; frames touched by reset are discarded.
  initial begin : mon
    logic [7:0] b;
    logic       ab, p, s;
    forever begin
      tick();
      if (rst === 1'b1 && tx === 1'b0) begin
        ab = 1'b0;
        p  = 1'b0;
        repeat (CD / 2) begin tick(); ab |= !rst; end
        for (int i = 0; i < 8; i++) begin
          repeat (CD) begin tick(); ab |= !rst; end
          b[i] = tx;
        end
`ifdef CPU_OUT_UART_PARITY_EN
        repeat (CD) begin tick(); ab |= !rst; end
        p = tx;
`endif
        repeat (CD) begin tick(); ab |= !rst; end
        s = tx;
        if (!ab) begin
          rxq.push_back(b);
          parq.push_back(p);
          if (s !== 1'b1) stop_err++;
        end
      end
    end
  end

  initial begin
    int lowc, sent, guard;
    rst = 1'b0; out_we = 1'b0; out_data = 8'h00;
    repeat (3) tick();
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", out_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_count", fifo_count, 0);

    // Single byte 0xA5, exact per-cycle waveform
    rst = 1'b1;
    out_we = 1'b1; out_data = 8'hA5;
    for (int k = 1; k <= FRAME + 3; k++) begin
      tick();
      out_we = 1'b0;
      chk($sformatf("t1_tx_k%0d", k), tx, exp_tx(k, 8'hA5));
      if (k == 1) chk("t1_busy_e1", busy, 1);
      if (k == 2) chk("t1_count_e2", fifo_count, 0);
      if (k == FRAME + 1) chk("t1_busy_stop", busy, 1);
      if (k == FRAME + 2) chk("t1_busy_end", busy, 0);
    end
    chk("t1_rx_n", rxq.size(), 1);
    chk("t1_rx", rxq[0], 8'hA5);
`ifdef CPU_OUT_UART_PARITY_EN
    chk("t1_par_a5", parq[0], 0);
    rxq.delete(); parq.delete();
    out_we = 1'b1; out_data = 8'h07;
    tick();
    out_we = 1'b0;
    wait_idle("t1p_idle");
    chk("t1p_rx", rxq[0], 8'h07);
    chk("t1p_par_07", parq[0], 1);
`endif

    // Ten back-to-back writes into an 8-deep FIFO
    rxq.delete(); parq.delete();
    for (int i = 1; i <= 10; i++) begin
      out_we = 1'b1; out_data = 8'(i);
      tick();
      if (i == 2) chk("t2_count_e2", fifo_count, 1);
      if (i == 8) chk("t2_full_e8", out_full, 0);
      if (i == 9) chk("t2_full_e9", out_full, 1);
    end
    out_we = 1'b0;
    chk("t2_ovf", overflow, 1);
    chk("t2_count_e10", fifo_count, 8);
    wait_idle("t2_idle");
    chk("t2_rx_n", rxq.size(), 9);
    for (int i = 0; i < 9; i++) chk($sformatf("t2_rx%0d", i), rxq[i], 32'(i + 1));
    chk("t2_ovf_sticky", overflow, 1);

    // Reset mid-DATA of 0x3C with three bytes queued
    rxq.delete(); parq.delete();
    for (int i = 0; i < 4; i++) begin
      out_we = 1'b1;
      out_data = (i == 0) ? 8'h3C : 8'(8'h11 * i);
      tick();
    end
    out_we = 1'b0;
    chk("t3_count", fifo_count, 3);
    repeat (6) tick();
    #3 rst = 1'b0;
    #1;
    chk("t3_tx_async", tx, 1);
    chk("t3_busy", busy, 0);
    chk("t3_count0", fifo_count, 0);
    chk("t3_ovf_clr", overflow, 0);
    @(posedge clk);
    #4 rst = 1'b1;
    lowc = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) lowc++;
    end
    chk("t3_quiet", lowc, 0);
    chk("t3_rx_n", rxq.size(), 0);

    // 20 bytes with the writer honouring out_full
    rxq.delete(); parq.delete();
    sent = 0; guard = 0; maxc = 0;
    while (sent < 20 && guard < 5000) begin
      if (!out_full) begin
        out_we = 1'b1; out_data = 8'(8'h60 + sent);
        sent++;
      end else begin
        out_we = 1'b0;
      end
      tick();
      guard++;
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
    end
    out_we = 1'b0;
    chk("t4_sent", sent, 20);
    wait_idle("t4_idle");
    chk("t4_ovf", overflow, 0);
    chk("t4_maxc", maxc, 8);
    chk("t4_rx_n", rxq.size(), 20);
    for (int i = 0; i < 20; i++) chk($sformatf("t4_rx%0d", i), rxq[i], 32'(8'h60 + i));

    // Pointer wrap: three rounds of six, drained between rounds
    rxq.delete(); parq.delete();
    maxc = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        out_we = 1'b1; out_data = 8'(8'h80 + r * 6 + i);
        tick();
        if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      end
      out_we = 1'b0;
      wait_idle($sformatf("t5_idle%0d", r));
    end
    chk("t5_maxc", maxc, 5);
    chk("t5_rx_n", rxq.size(), 18);
    for (int i = 0; i < 18; i++) chk($sformatf("t5_rx%0d", i), rxq[i], 32'(8'h80 + i));
    chk("t5_ovf", overflow, 0);
    chk("stop_bits", stop_err, 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
